// File: rtl/map_scan_tx.sv
// Snapshots the 256-cell map and scans it row by row into a 16-bit column shift register plus row decoder.
// Optional build macro MAP_SCAN_CURSOR_EN XORs a blinking edit cursor into the snapshot.
module map_scan_tx #(
    parameter int CLK_DIV  = 2,
    parameter int ROW_HOLD = 1000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [255:0] map,
    input  logic         start,
    input  logic [3:0]   cursor_x,
    input  logic [3:0]   cursor_y,
    input  logic         blink,
    output logic         busy,
    output logic         frame_done,
    output logic         ser_clk,
    output logic         ser_data,
    output logic         ser_latch,
    output logic [3:0]   row_sel,
    output logic         row_en
);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, LATCH, HOLD, DONE} state_t;

    localparam logic [7:0]  DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [15:0] HOLD_LAST = 16'(ROW_HOLD - 1);

    state_t        state, state_nx;
    logic [255:0]  snap;
    logic [255:0]  load_val;
    logic [3:0]    row, row_nx;
    logic [3:0]    bit_cnt, bit_nx;
    logic [7:0]    div_cnt, div_nx;
    logic [15:0]   hold_cnt, hold_nx;
    logic          sclk_nx, sdat_nx, slat_nx, ren_nx, busy_nx, done_nx;
    logic [3:0]    rsel_nx;
    logic [3:0]    next_col;
    logic [3:0]    row_inc;

`ifdef MAP_SCAN_CURSOR_EN
    assign load_val = map ^ (256'(blink) << {cursor_y, cursor_x});
`else
    logic unused_cursor;
    assign unused_cursor = ^{cursor_x, cursor_y, blink};
    assign load_val      = map;
`endif

    assign next_col = 4'd14 - bit_cnt;
    assign row_inc  = row + 4'd1;

    // Every output is computed one cycle ahead here so the ports come straight from flops.
    always_comb begin
        state_nx = state;
        row_nx   = row;
        bit_nx   = bit_cnt;
        div_nx   = div_cnt;
        hold_nx  = hold_cnt;
        sclk_nx  = ser_clk;
        sdat_nx  = ser_data;
        slat_nx  = ser_latch;
        rsel_nx  = row_sel;
        ren_nx   = row_en;
        busy_nx  = busy;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                busy_nx = 1'b0;
                if (start) begin
                    state_nx = LOAD;
                    busy_nx  = 1'b1;
                end
            end
            LOAD: begin
                state_nx = SHIFT;
                row_nx   = 4'd0;
                bit_nx   = 4'd0;
                div_nx   = 8'd0;
                sclk_nx  = 1'b0;
                sdat_nx  = load_val[15];
            end
            SHIFT: begin
                if (div_cnt == DIV_LAST) begin
                    div_nx = 8'd0;
                    if (!ser_clk) begin
                        sclk_nx = 1'b1;
                    end else begin
                        sclk_nx = 1'b0;
                        if (bit_cnt == 4'd15) begin
                            state_nx = LATCH;
                            slat_nx  = 1'b1;
                        end else begin
                            bit_nx  = bit_cnt + 4'd1;
                            sdat_nx = snap[{row, next_col}];
                        end
                    end
                end else begin
                    div_nx = div_cnt + 8'd1;
                end
            end
            LATCH: begin
                if (div_cnt == DIV_LAST) begin
                    div_nx   = 8'd0;
                    slat_nx  = 1'b0;
                    state_nx = HOLD;
                    ren_nx   = 1'b1;
                    rsel_nx  = row;
                    hold_nx  = 16'd0;
                end else begin
                    div_nx = div_cnt + 8'd1;
                end
            end
            HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    ren_nx = 1'b0;
                    if (row == 4'd15) begin
                        state_nx = DONE;
                        busy_nx  = 1'b0;
                        done_nx  = 1'b1;
                    end else begin
                        state_nx = SHIFT;
                        row_nx   = row_inc;
                        bit_nx   = 4'd0;
                        div_nx   = 8'd0;
                        sdat_nx  = snap[{row_inc, 4'd15}];
                    end
                end else begin
                    hold_nx = hold_cnt + 16'd1;
                end
            end
            DONE: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            row        <= 4'd0;
            bit_cnt    <= 4'd0;
            div_cnt    <= 8'd0;
            hold_cnt   <= 16'd0;
            ser_clk    <= 1'b0;
            ser_data   <= 1'b0;
            ser_latch  <= 1'b0;
            row_sel    <= 4'd0;
            row_en     <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            row        <= row_nx;
            bit_cnt    <= bit_nx;
            div_cnt    <= div_nx;
            hold_cnt   <= hold_nx;
            ser_clk    <= sclk_nx;
            ser_data   <= sdat_nx;
            ser_latch  <= slat_nx;
            row_sel    <= rsel_nx;
            row_en     <= ren_nx;
            busy       <= busy_nx;
            frame_done <= done_nx;
        end
    end

    // Snapshot content is irrelevant after reset, so it carries no reset.
    always_ff @(posedge clk) begin
        if (state == LOAD)
            snap <= load_val;
    end

endmodule
